// File: rtl/sram_buf_pkg.sv
// Shared types for the banked packet buffer. Used by the write controller,
// the read-side scheduler and the free-list manager.
package sram_buf_pkg;

  localparam int DEF_NRAMWIDTH = 5;
  localparam int DEF_AWIDTH    = 13;
  localparam int DEF_BLKWIDTH  = 6;
  localparam int DEF_LENWIDTH  = DEF_BLKWIDTH + 1;
  localparam int BUFAWIDTH     = DEF_NRAMWIDTH + DEF_AWIDTH;

  // Full buffer address: {bank, per-bank word offset}
  typedef logic [BUFAWIDTH-1:0] buf_addr_t;

  // Packet descriptor handed to the read/scheduling side
  typedef struct packed {
    buf_addr_t                 addr;
    logic [DEF_LENWIDTH-1:0]   len;
    logic                      err;
  } pkt_desc_t;

  // Write controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SOP,
    ST_WRITE,
    ST_FLUSH,
    ST_DESC
  } wr_state_t;

endpackage

// File: rtl/sram_wr_ctrl.sv
// Write-side front end of the banked packet buffer. Takes one free block
// pointer per packet, writes the SOP/EOP framed word stream into consecutive
// words of that block through SRAM port A, then presents a descriptor.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for a free block pointer
// ST_WAIT_SOP | block held, discarding (and counting) words until a SOP
// ST_WRITE    | storing packet words at base + wcnt
// ST_FLUSH    | packet exceeded one block, absorbing words until EOP
// ST_DESC     | descriptor presented, waiting for desc_ready_in
module sram_wr_ctrl
  import sram_buf_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int NRAMWIDTH = DEF_NRAMWIDTH,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int BLKWIDTH  = DEF_BLKWIDTH,
  parameter int LENWIDTH  = DEF_LENWIDTH
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          s_valid_in,
  output logic                          s_ready_out,
  input  logic [DWIDTH-1:0]             s_data_in,
  input  logic                          s_sop_in,
  input  logic                          s_eop_in,
  input  logic                          ptr_valid_in,
  output logic                          ptr_ready_out,
  input  logic [NRAMWIDTH+AWIDTH-1:0]   ptr_in,
  output logic                          sram_en_out,
  output logic                          sram_we_out,
  output logic [NRAMWIDTH+AWIDTH-1:0]   sram_addr_out,
  output logic [DWIDTH-1:0]             sram_d_out,
  output logic                          desc_valid_out,
  input  logic                          desc_ready_in,
  output logic [NRAMWIDTH+AWIDTH-1:0]   desc_addr_out,
  output logic [LENWIDTH-1:0]           desc_len_out,
  output logic                          desc_err_out,
  output logic [15:0]                   drop_cnt_out
);

  localparam int BW = NRAMWIDTH + AWIDTH;
  localparam logic [BW-1:0] BLK_MASK = {{(BW-BLKWIDTH){1'b0}}, {BLKWIDTH{1'b1}}};
  localparam logic [LENWIDTH-1:0] MAX_LEN = LENWIDTH'(1) << BLKWIDTH;

  wr_state_t             state_q, state_d;
  logic [BW-1:0]         base_q;
  logic [BLKWIDTH-1:0]   wcnt_q, wcnt_d;
  logic [LENWIDTH-1:0]   len_q, len_d;
  logic                  err_q, err_d;
  logic                  wr_d;
  logic                  drop_d;
  logic                  s_fire;
  logic                  ptr_fire;
  logic                  wr_q;
  logic [BW-1:0]         wr_addr_q;
  logic [DWIDTH-1:0]     wr_data_q;
  logic [15:0]           drop_cnt_q;

  // Ready outputs decode the state; gated by reset so they drop immediately
  always_comb begin
    s_ready_out   = !rst_in && (state_q inside {ST_WAIT_SOP, ST_WRITE, ST_FLUSH});
    ptr_ready_out = !rst_in && (state_q == ST_IDLE);
    s_fire        = s_valid_in && s_ready_out;
    ptr_fire      = ptr_valid_in && ptr_ready_out;
  end

  // Next-state, word counter and descriptor field update
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    len_d   = len_q;
    err_d   = err_q;
    wr_d    = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ptr_fire) begin
          wcnt_d  = '0;
          state_d = ST_WAIT_SOP;
        end
      end
      ST_WAIT_SOP: begin
        if (s_fire) begin
          if (s_sop_in) begin
            wr_d   = 1'b1;
            wcnt_d = BLKWIDTH'(1);
            err_d  = 1'b0;
            if (s_eop_in) begin
              len_d   = LENWIDTH'(1);
              state_d = ST_DESC;
            end else begin
              state_d = ST_WRITE;
            end
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (s_fire) begin
          wr_d   = 1'b1;
          wcnt_d = wcnt_q + BLKWIDTH'(1);
          if (s_eop_in) begin
            len_d   = LENWIDTH'(wcnt_q) + LENWIDTH'(1);
            state_d = ST_DESC;
          end else if (wcnt_q == '1) begin
            // last word of the block without EOP: truncate the packet
            len_d   = MAX_LEN;
            err_d   = 1'b1;
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (s_fire && s_eop_in) state_d = ST_DESC;
      end
      ST_DESC: begin
        if (desc_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and descriptor registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
      if (ptr_fire) base_q <= ptr_in & ~BLK_MASK;
    end
  end

  // Port A strobe: one registered write per accepted packet word
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_q <= wr_d;
      if (wr_d) begin
        wr_addr_q <= {base_q[BW-1:BLKWIDTH], wcnt_q};
        wr_data_q <= s_data_in;
      end
    end
  end

  // Saturating count of out-of-frame words dropped while waiting for SOP
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_cnt_q <= '0;
    end else if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign sram_en_out    = wr_q;
  assign sram_we_out    = wr_q;
  assign sram_addr_out  = wr_addr_q;
  assign sram_d_out     = wr_data_q;
  assign desc_valid_out = (state_q == ST_DESC);
  assign desc_addr_out  = base_q;
  assign desc_len_out   = len_q;
  assign desc_err_out   = err_q;
  assign drop_cnt_out   = drop_cnt_q;

endmodule

// File: tb/tb_sram_wr_ctrl.sv
// Bench for sram_wr_ctrl: packet-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sram_wr_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        s_valid_in = 1'b0;
  logic        s_ready_out;
  logic [31:0] s_data_in = '0;
  logic        s_sop_in = 1'b0;
  logic        s_eop_in = 1'b0;
  logic        ptr_valid_in = 1'b0;
  logic        ptr_ready_out;
  logic [17:0] ptr_in = '0;
  logic        sram_en_out, sram_we_out;
  logic [17:0] sram_addr_out;
  logic [31:0] sram_d_out;
  logic        desc_valid_out;
  logic        desc_ready_in = 1'b1;
  logic [17:0] desc_addr_out;
  logic [6:0]  desc_len_out;
  logic        desc_err_out;
  logic [15:0] drop_cnt_out;

  sram_wr_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s_valid_in(s_valid_in), .s_ready_out(s_ready_out), .s_data_in(s_data_in),
    .s_sop_in(s_sop_in), .s_eop_in(s_eop_in),
    .ptr_valid_in(ptr_valid_in), .ptr_ready_out(ptr_ready_out), .ptr_in(ptr_in),
    .sram_en_out(sram_en_out), .sram_we_out(sram_we_out),
    .sram_addr_out(sram_addr_out), .sram_d_out(sram_d_out),
    .desc_valid_out(desc_valid_out), .desc_ready_in(desc_ready_in),
    .desc_addr_out(desc_addr_out), .desc_len_out(desc_len_out),
    .desc_err_out(desc_err_out), .drop_cnt_out(drop_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc_n, act, exp);
    end
  endtask

  // Reference model: packet bookkeeping, not a state machine copy
  logic        m_have_ptr = 0;   // a block pointer is held
  logic        m_in_pkt = 0;     // a SOP has been seen for the held block
  logic        m_desc = 0;       // a descriptor is waiting for the consumer
  int          m_total = 0;      // words received in the current packet
  logic [17:0] m_base = '0;
  logic        e_en = 0;
  logic [17:0] e_addr = '0;
  logic [31:0] e_data = '0;
  logic [17:0] e_daddr = '0;
  logic [6:0]  e_len = '0;
  logic        e_err = 0;
  int          e_drop = 0;

  initial forever begin
    @(posedge clk_in or posedge rst_in);
    if (rst_in) begin
      m_have_ptr = 0; m_in_pkt = 0; m_desc = 0; m_total = 0; m_base = '0;
      e_en = 0; e_drop = 0;
    end else begin
      bit s_acc, p_acc;
      s_acc = s_valid_in && m_have_ptr && !m_desc;
      p_acc = ptr_valid_in && !m_have_ptr && !m_desc;
      e_en = 0;
      if (m_desc) begin
        if (desc_ready_in) m_desc = 0;
      end else if (p_acc) begin
        m_have_ptr = 1;
        m_in_pkt   = 0;
        m_base     = ptr_in & ~18'h3F;
      end else if (s_acc) begin
        if (!m_in_pkt && !s_sop_in) begin
          if (e_drop < 65535) e_drop++;
        end else begin
          if (!m_in_pkt) begin m_in_pkt = 1; m_total = 0; end
          if (m_total < 64) begin
            e_en   = 1;
            e_addr = m_base + 18'(m_total);
            e_data = s_data_in;
          end
          m_total++;
          if (s_eop_in) begin
            m_desc     = 1;
            m_have_ptr = 0;
            m_in_pkt   = 0;
            e_daddr    = m_base;
            e_len      = 7'((m_total > 64) ? 64 : m_total);
            e_err      = (m_total > 64);
          end
        end
      end
    end
  end

  always @(posedge clk_in) cyc_n <= cyc_n + 1;

  // Logs of observed strobes and descriptors for the literal checks
  int          wr_cyc[$];
  logic [17:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          ds_cyc[$];
  logic [17:0] ds_addr[$];
  logic [6:0]  ds_len[$];
  logic        ds_err[$];
  logic        prev_dv = 0;

  // Per-cycle compare against the model, mid-cycle
  initial forever begin
    @(negedge clk_in);
    if (rst_in) begin
      prev_dv = 0;
    end else begin
      chk("s_ready", 64'(s_ready_out), 64'(m_have_ptr && !m_desc));
      chk("ptr_ready", 64'(ptr_ready_out), 64'(!m_have_ptr && !m_desc));
      chk("sram_en", 64'(sram_en_out), 64'(e_en));
      chk("sram_we", 64'(sram_we_out), 64'(e_en));
      if (e_en) begin
        chk("sram_addr", 64'(sram_addr_out), 64'(e_addr));
        chk("sram_d", 64'(sram_d_out), 64'(e_data));
      end
      chk("desc_valid", 64'(desc_valid_out), 64'(m_desc));
      if (m_desc) begin
        chk("desc_addr", 64'(desc_addr_out), 64'(e_daddr));
        chk("desc_len", 64'(desc_len_out), 64'(e_len));
        chk("desc_err", 64'(desc_err_out), 64'(e_err));
      end
      chk("drop_cnt", 64'(drop_cnt_out), 64'(e_drop));
      if (sram_en_out) begin
        wr_cyc.push_back(cyc_n); wr_addr.push_back(sram_addr_out); wr_data.push_back(sram_d_out);
      end
      if (desc_valid_out && !prev_dv) begin
        ds_cyc.push_back(cyc_n); ds_addr.push_back(desc_addr_out);
        ds_len.push_back(desc_len_out); ds_err.push_back(desc_err_out);
      end
      prev_dv = desc_valid_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_in); #1;
  endtask

  task automatic send_ptr(input logic [17:0] p);
    bit acc = 0;
    ptr_valid_in = 1; ptr_in = p;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk_in); acc = ptr_ready_out;
      @(posedge clk_in); #1;
    end
    ptr_valid_in = 0;
    chk("ptr_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic sop, input logic eop);
    bit acc = 0;
    s_valid_in = 1; s_data_in = d; s_sop_in = sop; s_eop_in = eop;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk_in); acc = s_ready_out;
      @(posedge clk_in); #1;
    end
    s_valid_in = 0; s_sop_in = 0; s_eop_in = 0;
    chk("word_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_pkt(input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) send_word(seed + 32'(i), i == 0, i == n - 1);
  endtask

  task automatic wait_desc(input int d0);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (ds_cyc.size() > d0) got = 1;
      else cyc();
    end
    chk("desc_seen", 64'(got), 64'd1);
    cyc(); cyc();
  endtask

  initial begin
    int s0, d0, eop_pct;

    repeat (3) cyc();
    @(negedge clk_in);
    chk("rst_s_ready", 64'(s_ready_out), 0);
    chk("rst_ptr_ready", 64'(ptr_ready_out), 0);
    chk("rst_en", 64'(sram_en_out), 0);
    chk("rst_desc_valid", 64'(desc_valid_out), 0);
    chk("rst_drop", 64'(drop_cnt_out), 0);
    @(posedge clk_in); #1;
    rst_in = 0;
    cyc();

    // 3-word packet into block of pointer 0x00047
    s0 = wr_cyc.size(); d0 = ds_cyc.size();
    send_ptr(18'h00047);
    send_pkt(3, 32'hD000_0000);
    wait_desc(d0);
    if (wr_cyc.size() >= s0 + 3 && ds_cyc.size() > d0) begin
      chk("t1_a0", 64'(wr_addr[s0]), 64'h40);
      chk("t1_a1", 64'(wr_addr[s0+1]), 64'h41);
      chk("t1_a2", 64'(wr_addr[s0+2]), 64'h42);
      chk("t1_d2", 64'(wr_data[s0+2]), 64'hD000_0002);
      chk("t1_b2b", 64'(wr_cyc[s0+2] - wr_cyc[s0]), 64'd2);
      chk("t1_desc_cyc", 64'(ds_cyc[d0]), 64'(wr_cyc[s0+2]));
      chk("t1_daddr", 64'(ds_addr[d0]), 64'h40);
      chk("t1_dlen", 64'(ds_len[d0]), 64'd3);
      chk("t1_derr", 64'(ds_err[d0]), 64'd0);
    end else chk("t1_logs", 64'(wr_cyc.size() - s0), 64'd3);

    // single sop+eop word, top block of the buffer
    s0 = wr_cyc.size(); d0 = ds_cyc.size();
    send_ptr(18'h3FFC0);
    send_word(32'hCAFE_F00D, 1, 1);
    wait_desc(d0);
    chk("t2_nwr", 64'(wr_cyc.size() - s0), 64'd1);
    if (wr_cyc.size() > s0 && ds_cyc.size() > d0) begin
      chk("t2_addr", 64'(wr_addr[s0]), 64'h3FFC0);
      chk("t2_dlen", 64'(ds_len[d0]), 64'd1);
      chk("t2_derr", 64'(ds_err[d0]), 64'd0);
    end

    // two stray words before SOP, then a normal packet
    s0 = wr_cyc.size(); d0 = ds_cyc.size();
    send_ptr(18'h00500);
    send_word(32'h5555_0001, 0, 0);
    send_word(32'h5555_0002, 0, 1);
    cyc();
    chk("t4_stray_nowr", 64'(wr_cyc.size() - s0), 64'd0);
    chk("t4_drop", 64'(drop_cnt_out), 64'd2);
    send_pkt(4, 32'hAB00_0000);
    wait_desc(d0);
    chk("t4_nwr", 64'(wr_cyc.size() - s0), 64'd4);
    if (ds_cyc.size() > d0) chk("t4_dlen", 64'(ds_len[d0]), 64'd4);

    // 70-word packet truncated to one block
    s0 = wr_cyc.size(); d0 = ds_cyc.size();
    send_ptr(18'h002A5);
    send_pkt(70, 32'h7000_0000);
    wait_desc(d0);
    chk("t3_nwr", 64'(wr_cyc.size() - s0), 64'd64);
    if (wr_cyc.size() >= s0 + 64 && ds_cyc.size() > d0) begin
      chk("t3_first", 64'(wr_addr[s0]), 64'h280);
      chk("t3_last", 64'(wr_addr[s0+63]), 64'h2BF);
      chk("t3_last_d", 64'(wr_data[s0+63]), 64'h7000_003F);
      chk("t3_dlen", 64'(ds_len[d0]), 64'd64);
      chk("t3_derr", 64'(ds_err[d0]), 64'd1);
    end

    // descriptor back-pressure for 5 cycles
    desc_ready_in = 0;
    send_ptr(18'h00A00);
    send_pkt(2, 32'h0000_0A00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      chk("t5_dv", 64'(desc_valid_out), 64'd1);
      chk("t5_sready", 64'(s_ready_out), 64'd0);
      chk("t5_pready", 64'(ptr_ready_out), 64'd0);
      chk("t5_daddr", 64'(desc_addr_out), 64'hA00);
      chk("t5_dlen", 64'(desc_len_out), 64'd2);
      if (k == 4) desc_ready_in = 1;
      @(posedge clk_in); #1;
    end
    @(negedge clk_in);
    chk("t5_idle_pready", 64'(ptr_ready_out), 64'd1);
    chk("t5_idle_dv", 64'(desc_valid_out), 64'd0);
    @(posedge clk_in); #1;

    // reset mid-packet after 10 writes
    d0 = ds_cyc.size();
    send_ptr(18'h00100);
    for (int i = 0; i < 10; i++) send_word(32'h1000_0000 + 32'(i), i == 0, 0);
    cyc();
    #2 rst_in = 1;
    #1;
    chk("t6_en", 64'(sram_en_out), 0);
    chk("t6_we", 64'(sram_we_out), 0);
    chk("t6_sready", 64'(s_ready_out), 0);
    chk("t6_pready", 64'(ptr_ready_out), 0);
    chk("t6_dv", 64'(desc_valid_out), 0);
    chk("t6_drop", 64'(drop_cnt_out), 0);
    chk("t6_addr", 64'(sram_addr_out), 0);
    cyc(); cyc();
    rst_in = 0;
    cyc(); cyc();
    chk("t6_nodesc", 64'(ds_cyc.size()), 64'(d0));
    s0 = wr_cyc.size();
    send_ptr(18'h01234);
    send_pkt(5, 32'h6000_0000);
    wait_desc(d0);
    chk("t6_nwr", 64'(wr_cyc.size() - s0), 64'd5);
    if (ds_cyc.size() > d0) begin
      chk("t6_daddr", 64'(ds_addr[d0]), 64'h01200);
      chk("t6_dlen", 64'(ds_len[d0]), 64'd5);
    end

    // randomized traffic, model checks every cycle
    eop_pct = 15;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) eop_pct = (eop_pct == 15) ? 1 : 15;
      s_valid_in    = $urandom_range(0, 99) < 70;
      s_sop_in      = $urandom_range(0, 99) < 25;
      s_eop_in      = $urandom_range(0, 99) < eop_pct;
      s_data_in     = $urandom;
      ptr_valid_in  = $urandom_range(0, 99) < 50;
      ptr_in        = 18'($urandom);
      desc_ready_in = $urandom_range(0, 99) < 60;
      cyc();
    end
    s_valid_in = 0; ptr_valid_in = 0; desc_ready_in = 1;
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_wr_ctrl.md
Name: sram_wr_ctrl

Overview:
- Write-side front end of the banked packet buffer. Accepts a word stream framed by SOP/EOP and takes a free block pointer per packet.
- Writes the packet words to consecutive addresses of one block through the buffer's write port, then emits a descriptor (base address, length, error) for the read/scheduling side.
- Sits directly upstream of the banked dual-port SRAM array and drives its port A (en/we/addr/data).

Parameters:
- DWIDTH, 32, data word width
- NRAMWIDTH, 5, bank-select address bits
- AWIDTH, 13, per-bank word address bits
- BLKWIDTH, 6, log2 of block size in words (MAXLEN = 64); must be <= AWIDTH
- LENWIDTH, 7, descriptor length width (BLKWIDTH+1)

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous reset, active-high
- s_valid_in  input  1  stream word valid
- s_ready_out  output  1  stream ready
- s_data_in  input  DWIDTH  stream data
- s_sop_in  input  1  first word of packet
- s_eop_in  input  1  last word of packet
- ptr_valid_in  input  1  free block pointer valid
- ptr_ready_out  output  1  pointer consumed
- ptr_in  input  NRAMWIDTH+AWIDTH  free block base address
- sram_en_out  output  1  port A enable
- sram_we_out  output  1  port A write enable
- sram_addr_out  output  NRAMWIDTH+AWIDTH  port A address {bank, offset}
- sram_d_out  output  DWIDTH  port A write data
- desc_valid_out  output  1  descriptor valid
- desc_ready_in  input  1  descriptor accepted
- desc_addr_out  output  NRAMWIDTH+AWIDTH  packet base address
- desc_len_out  output  LENWIDTH  words stored (1..64)
- desc_err_out  output  1  packet truncated
- drop_cnt_out  output  16  saturating count of discarded out-of-frame words

Behaviour:
- Reset: state IDLE. All outputs 0, including the ready signals. Reset is asynchronous and takes effect immediately.
- FSM states: IDLE, WAIT_SOP, WRITE, FLUSH, DESC.
- IDLE:
  - ptr_ready_out=1, s_ready_out=0.
  - On ptr handshake, latch base = ptr_in with the low BLKWIDTH bits forced to 0, then go to WAIT_SOP.
- WAIT_SOP:
  - s_ready_out=1.
  - An accepted word without sop is discarded; drop_cnt_out increments and saturates at 0xFFFF.
  - An accepted word with sop is written at offset 0 and wcnt=1. If eop is also set, go to DESC with len=1. Otherwise go to WRITE.
- WRITE:
  - s_ready_out=1.
  - Each accepted word is written at {base[hi:BLKWIDTH], wcnt[BLKWIDTH-1:0]} and wcnt increments. A sop mid-packet is ignored and the word is treated as data.
  - If eop is set, go to DESC with len=wcnt+1.
  - If word 64 is accepted without eop, go to FLUSH with len=64 and err=1.
- FLUSH:
  - s_ready_out=1.
  - Words are accepted and discarded with no SRAM write and no drop_cnt change.
  - On eop, go to DESC.
- DESC:
  - desc_valid_out=1 with addr/len/err stable; s_ready_out=0, ptr_ready_out=0.
  - On desc_ready_in, clear desc_valid_out and go to IDLE.
- Write port timing:
  - Word accepted in cycle t: sram_en_out=sram_we_out=1 in cycle t+1 for exactly one cycle, with registered addr/data. Otherwise en/we=0.
  - Back-to-back words give back-to-back strobes, one word per cycle, no bubbles.
- Descriptor timing: for eop accepted in cycle t, desc_valid_out rises in cycle t+1, the same cycle as the last write strobe. The memory commits at the end of t+1, so any consumer read issued at t+2 or later sees the data.
- Address arithmetic: a block never crosses a bank because BLKWIDTH <= AWIDTH. The offset does not wrap inside a block; exceeding 64 words is handled by FLUSH.
- Throughput: per-packet overhead is 1 IDLE cycle plus 1 DESC cycle minimum.
- Reset mid-packet: the packet and its pointer are abandoned and no descriptor is emitted. The free-list owner reclaims pointers on reset.

Decomposition:
- Package sram_buf_pkg holds:
  - shared NRAMWIDTH/AWIDTH/BLKWIDTH defaults
  - typedef buf_addr_t (NRAMWIDTH+AWIDTH bits)
  - struct pkt_desc_t {addr, len, err}
  - enum wr_state_t
- The package is shared with the read-side scheduler and the free-list manager.
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Pointer 0x00047, 3-word packet D0..D2 with sop on D0 and eop on D2 → writes at addr 0x00040, 0x00041, 0x00042 in consecutive cycles t+1..t+3. Descriptor addr=0x00040, len=3, err=0 with valid in cycle t+3.
- Single word with sop+eop, pointer 0x3FFC0 → one write at 0x3FFC0; descriptor len=1, err=0.
- 70-word packet → 64 writes at base..base+63, last 6 words absorbed with no strobe; descriptor len=64, err=1.
- Two stray non-sop words in WAIT_SOP, then a valid packet → drop_cnt_out=2, no strobes for the strays, packet stored normally.
- desc_ready_in held low 5 cycles → descriptor stable, s_ready_out=0, ptr_ready_out=0 for all 5 cycles; IDLE is reached one cycle after ready.
- rst_in pulsed mid-packet after 10 writes → outputs 0 immediately and no descriptor; the next pointer/packet completes correctly.
